// File: rtl/evt_spike_emitter_if.sv
// Spike event output stream: the emitter drives valid/addr and the consumer drives ready.
interface evt_spike_emitter_if #(
    parameter int unsigned ADDR_WIDTH = 6
) ();
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;

    modport master (output valid, output addr, input ready);
    modport slave  (input valid, input addr, output ready);
endinterface

// File: rtl/evt_spike_emitter.sv
// Leaky threshold evaluator for one neuron per sequencer read.
// Emits spike events on a stream and grants the sequencer to advance.
module evt_spike_emitter #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned STATE_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [STATE_WIDTH-1:0] cfg_threshold_i,
    input  logic [STATE_WIDTH-1:0] cfg_leak_i,
    input  logic [STATE_WIDTH-1:0] cfg_reset_val_i,
    input  logic                   mem_re_i,
    input  logic [ADDR_WIDTH-1:0]  mem_raddr_i,
    input  logic [STATE_WIDTH-1:0] mem_rdata_i,
    input  logic                   seq_done_i,
    input  logic                   seq_ready_i,
    output logic [STATE_WIDTH-1:0] mem_wdata_o,
    output logic                   spike_grant_o,
    evt_spike_emitter_if.master    spike,
    output logic [CNT_WIDTH-1:0]   spike_cnt_o,
    output logic                   busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StEval,
        StEmit,
        StGrant,
        StWrite
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [STATE_WIDTH-1:0] wdata_q, wdata_d;
    logic                   fire_q, fire_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   grant_q;
    logic [STATE_WIDTH-1:0] leaked;
    logic                   grant;
    logic                   valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fire_d  = fire_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        valid   = 1'b0;
        // Leak saturates at zero rather than wrapping.
        leaked  = (mem_rdata_i > cfg_leak_i) ? mem_rdata_i - cfg_leak_i : '0;

        unique case (state_q)
            StIdle: begin
                if (mem_re_i && !seq_done_i) begin
                    addr_d  = mem_raddr_i;
                    state_d = StFetch;
                end else if (seq_ready_i && !grant_q) begin
                    grant = 1'b1;
                end
            end
            StFetch: begin
                fire_d  = (leaked >= cfg_threshold_i);
                wdata_d = fire_d ? cfg_reset_val_i : leaked;
                state_d = StEval;
            end
            StEval: state_d = fire_q ? StEmit : StGrant;
            StEmit: begin
                valid = 1'b1;
                if (spike.ready) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                grant   = 1'b1;
                state_d = StWrite;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort overrides everything, including an in-flight spike.
        if (clear_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            valid   = 1'b0;
            grant   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            fire_q  <= 1'b0;
            cnt_q   <= '0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fire_q  <= fire_d;
            cnt_q   <= cnt_d;
            grant_q <= grant;
        end
    end

    assign spike.valid   = valid;
    assign spike.addr    = addr_q;
    assign spike_grant_o = grant;
    assign mem_wdata_o   = wdata_q;
    assign spike_cnt_o   = cnt_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_evt_spike_emitter.sv
// Randomised scoreboard bench for evt_spike_emitter; a narrow counter keeps saturation reachable.
module tb_evt_spike_emitter;

    localparam int unsigned AW   = 6;
    localparam int unsigned SW   = 8;
    localparam int unsigned CntW = 5;
    localparam int unsigned CntMax = (1 << CntW) - 1;
    localparam int BpCycles = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [SW-1:0] thr = '0, leak = '0, rv = '0;
    logic          re = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [SW-1:0] rdata = '0;
    logic          done = 1'b0;
    logic          sready = 1'b0;
    logic [SW-1:0] wdata;
    logic          grant;
    logic [CntW-1:0] cnt;
    logic          busy;

    evt_spike_emitter_if #(.ADDR_WIDTH(AW)) spike_if ();

    evt_spike_emitter #(
        .ADDR_WIDTH (AW),
        .STATE_WIDTH(SW),
        .CNT_WIDTH  (CntW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .cfg_threshold_i(thr),
        .cfg_leak_i     (leak),
        .cfg_reset_val_i(rv),
        .mem_re_i       (re),
        .mem_raddr_i    (raddr),
        .mem_rdata_i    (rdata),
        .seq_done_i     (done),
        .seq_ready_i    (sready),
        .mem_wdata_o    (wdata),
        .spike_grant_o  (grant),
        .spike          (spike_if.master),
        .spike_cnt_o    (cnt),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [AW-1:0] exp_q[$];
    int model_cnt = 0;
    int ready_mode = 0;  // 0 low, 1 high, 2 random, 3 low for BpCycles valid cycles
    int bp_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Consumer-side ready driver.
    initial begin
        spike_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: spike_if.ready = 1'b1;
                2: spike_if.ready = 1'($urandom_range(0, 1));
                3: begin
                    spike_if.ready = (bp_left == 0);
                    if (spike_if.valid && bp_left > 0) bp_left--;
                end
                default: spike_if.ready = 1'b0;
            endcase
        end
    end

    // Monitor: stream stability, scoreboard pops, grant spacing.
    logic          prev_v = 1'b0, prev_r = 1'b0, prev_g = 1'b0;
    logic [AW-1:0] prev_a = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_v && !prev_r && !clear) begin
                chk("stable_valid", 32'(spike_if.valid), 32'd1);
                chk("stable_addr", 32'(spike_if.addr), 32'(prev_a));
            end
            if (spike_if.valid && spike_if.ready) begin
                if (exp_q.size() == 0) chk("unexpected_spike", 32'd1, 32'd0);
                else chk("spike_addr", 32'(spike_if.addr), 32'(exp_q.pop_front()));
            end
            if (grant) chk("grant_gap", 32'(prev_g), 32'd0);
        end
        prev_v = spike_if.valid;
        prev_r = spike_if.ready;
        prev_a = spike_if.addr;
        prev_g = grant;
    end

    // One neuron visit: predict from the leak/threshold rules, drive the read, follow to WRITE.
    task automatic visit(input logic [AW-1:0] a, input logic [SW-1:0] d, input bit abort);
        logic [SW-1:0] lk, wd;
        bit f;
        int k;
        lk = (d > leak) ? d - leak : 8'd0;
        f  = (lk >= thr);
        wd = f ? rv : lk;
        if (f) exp_q.push_back(a);
        if (ready_mode == 3) bp_left = BpCycles;
        re = 1'b1;
        raddr = a;
        @(posedge clk);
        #1;
        re = 1'b0;
        rdata = d;
        raddr = AW'($urandom);
        if (abort) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!spike_if.valid && k < 10);
            chk("abort_valid_seen", 32'(spike_if.valid), 32'd1);
            @(posedge clk);
            #1;
            clear = 1'b1;
            @(negedge clk);
            chk("clear_valid_drop", 32'(spike_if.valid), 32'd0);
            @(posedge clk);
            #1;
            clear = 1'b0;
            @(negedge clk);
            chk("clear_busy", 32'(busy), 32'd0);
            chk("clear_cnt", 32'(cnt), 32'd0);
            chk("clear_keeps_wdata", 32'(wdata), 32'(wd));
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            model_cnt = 0;
            @(posedge clk);
            #1;
            return;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!grant && k < 300);
        chk("grant_seen", 32'(grant), 32'd1);
        if (!f) chk("grant_latency_nofire", 32'(k), 32'd3);
        else if (ready_mode == 1) chk("grant_latency_fire", 32'(k), 32'd4);
        else if (ready_mode == 3) chk("grant_latency_bp", 32'(k), 32'(4 + BpCycles));
        if (f) model_cnt = (model_cnt == int'(CntMax)) ? model_cnt : model_cnt + 1;
        @(posedge clk);
        #1;
        chk("write_busy", 32'(busy), 32'd1);
        chk("write_wdata", 32'(wdata), 32'(wd));
        chk("spike_cnt", 32'(cnt), 32'(model_cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(spike_if.valid), 32'd0);
        chk("rst_addr", 32'(spike_if.addr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No fire, fire, backpressure.
        thr = 8'd50; leak = 8'd3; rv = 8'd0;
        ready_mode = 1;
        visit(6'd5, 8'd40, 1'b0);
        visit(6'd9, 8'd60, 1'b0);
        ready_mode = 3;
        visit(6'd9, 8'd60, 1'b0);

        // Leak underflow, then zero threshold.
        ready_mode = 1;
        thr = 8'd1; leak = 8'd5; rv = 8'd77;
        visit(6'd12, 8'd2, 1'b0);
        thr = 8'd0;
        visit(6'd13, 8'd2, 1'b0);

        // Sweep 0..7, then the masked wrap-around read and stop-phase grants.
        thr = 8'd90; leak = 8'd0; rv = 8'd0;
        for (int i = 0; i < 8; i++) visit(AW'(i), 8'd100, 1'b0);
        chk("sweep_drained", 32'(exp_q.size()), 32'd0);
        re = 1'b1; raddr = '0; done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_masks_busy", 32'(busy), 32'd0);
            chk("done_no_grant", 32'(grant), 32'd0);
        end
        @(posedge clk);
        #1;
        re = 1'b0;
        sready = 1'b1;
        g = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (grant) g++;
        end
        chk("stop_grant_count", 32'(g), 32'd3);
        @(posedge clk);
        #1;
        sready = 1'b0; done = 1'b0;
        @(posedge clk);
        #1;

        // Randomised visits.
        ready_mode = 2;
        for (int i = 0; i < 60; i++) begin
            if (i % 10 == 0) begin
                thr  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                leak = 8'($urandom_range(0, 40));
                rv   = 8'($urandom);
            end
            visit(AW'($urandom), 8'($urandom), 1'b0);
        end

        // Abort mid-EMIT.
        ready_mode = 0;
        thr = 8'd10; leak = 8'd1; rv = 8'd3;
        visit(6'd33, 8'd200, 1'b1);

        // Counter saturation.
        ready_mode = 1;
        thr = 8'd0;
        while (model_cnt < int'(CntMax)) visit(AW'($urandom), 8'($urandom), 1'b0);
        visit(6'd63, 8'd1, 1'b0);
        chk("cnt_saturated", 32'(cnt), 32'(CntMax));
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
